// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 4x4 matrix keypad that feeds the dual seven-segment
// display. The columns are driven low one at a time and the rows are sampled.
// Press and release are both debounced, each accepted press gives one
// key_valid pulse, and the last two keys are kept as a digit pair for the
// display multiplexer.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When defined, a key held in HOLD re-enters PRESSED every REPEAT_CYCLES
//   cycles. The period includes the PRESSED cycle, so pulses are exactly
//   REPEAT_CYCLES apart. REPEAT_CYCLES must be at least 2.
//   When undefined, no repeat counter is built and each press gives exactly
//   one pulse.
//
// Handshake: key_valid is a one-cycle strobe with no ready/back-pressure.
// key_code, digit_new and digit_old are already updated in the cycle where
// key_valid is high, and they hold their values until the next accepted key.
//
// Ports
//   clk        in   1  single clock domain
//   reset      in   1  synchronous, active-high
//   rows       in   4  keypad rows, active-low, asynchronous to clk
//   cols       out  4  column drive, one-hot-low (bit n low = column n)
//   key_valid  out  1  one-cycle pulse per accepted key
//   key_code   out  4  hex code of the last accepted key
//   digit_new  out  4  most recent key
//   digit_old  out  4  key before digit_new
//   key_held   out  1  high in HOLD and RELEASE_DB
//   state_dbg  out  3  current FSM state encoding (debug)
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 48_000,
    parameter int DEBOUNCE_CYCLES = 960_000,
    parameter int REPEAT_CYCLES   = 24_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_held,
    output logic [2:0] state_dbg
);

    localparam int MAX_CNT = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SCAN       = 3'd0,
        ST_DEBOUNCE   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_HOLD       = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       rs_meta;
    logic [3:0]       rs;
    logic [3:0]       cap;
    logic             rs_single;
    logic             rs_match;
    logic             rs_idle;
    logic             scan_last;
    logic             db_last;
    logic             rpt_fire;
    logic [3:0]       map_code;

    // Position of the single low bit in a one-cold pattern.
    function automatic logic [1:0] cold_idx(input logic [3:0] v);
        case (v)
            4'b1110: cold_idx = 2'd0;
            4'b1101: cold_idx = 2'd1;
            4'b1011: cold_idx = 2'd2;
            default: cold_idx = 2'd3;
        endcase
    endfunction

    // Physical key layout: {row, col} -> hex code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'hE;
            4'b11_01: key_map = 4'h0;
            4'b11_10: key_map = 4'hF;
            default:  key_map = 4'hD;
        endcase
    endfunction

    // Column drive advances 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] rot(input logic [3:0] v);
        rot = {v[2:0], v[3]};
    endfunction

    // Two-flop synchronizer; every decision below uses rs only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    always_comb begin
        rs_single = 1'b0;
        case (rs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: rs_single = 1'b1;
            default:                            rs_single = 1'b0;
        endcase
    end

    assign rs_match  = (rs == cap);
    assign rs_idle   = (rs == 4'hF);
    assign scan_last = (cnt == SCAN_LAST);
    assign db_last   = (cnt == DB_LAST);
    // cols is frozen from capture until release, so it names the key's column.
    assign map_code  = key_map(cold_idx(cap), cold_idx(cols));

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;

    // The PRESSED cycle counts as the first cycle of a repeat period, so
    // consecutive pulses are exactly REPEAT_CYCLES apart. Entering HOLD from
    // RELEASE_DB starts a fresh period at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt <= '0;
        end else if (state == ST_PRESSED) begin
            rpt_cnt <= RPT_W'(1);
        end else if (state == ST_HOLD && next_state == ST_HOLD) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end else begin
            rpt_cnt <= '0;
        end
    end

    assign rpt_fire = (state == ST_HOLD) && !rs_idle && (rpt_cnt == RPT_LAST);
`else
    assign rpt_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SCAN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_SCAN: begin
                if (scan_last && rs_single) begin
                    next_state = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!rs_match) begin
                    next_state = ST_SCAN;
                end else if (db_last) begin
                    next_state = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (rs_idle) begin
                    next_state = ST_RELEASE_DB;
                end else if (rpt_fire) begin
                    next_state = ST_PRESSED;
                end
            end
            ST_RELEASE_DB: begin
                if (!rs_idle) begin
                    next_state = ST_HOLD;
                end else if (db_last) begin
                    next_state = ST_SCAN;
                end
            end
            default: begin
                next_state = ST_SCAN;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        key_valid = (state == ST_PRESSED);
        key_held  = (state == ST_HOLD) || (state == ST_RELEASE_DB);
        state_dbg = state;
    end

    // Datapath: dwell/debounce counter, column drive, captured row pattern
    // and the key/digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            cols      <= 4'b1110;
            cap       <= 4'hF;
            key_code  <= 4'h0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (scan_last) begin
                        cnt <= '0;
                        if (rs_single) begin
                            cap <= rs;
                        end else begin
                            cols <= rot(cols);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!rs_match) begin
                        cnt  <= '0;
                        cols <= rot(cols);
                    end else if (db_last) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!rs_idle) begin
                        cnt <= '0;
                    end else if (db_last) begin
                        cnt  <= '0;
                        cols <= rot(cols);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase

            // Loaded on the edge into PRESSED so the new code and digit pair
            // are visible in the same cycle as key_valid.
            if (next_state == ST_PRESSED) begin
                key_code  <= map_code;
                digit_new <= map_code;
                digit_old <= digit_new;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int REPEAT_CYCLES   = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_held;
    logic [2:0] state_dbg;

    keypad_scan_ctrl #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digit_new (digit_new),
        .digit_old (digit_old),
        .key_held  (key_held),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- keypad model ----------------
    // pat[c] is the row pattern seen while column c is driven low.
    logic [3:0] pat [4];

    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!cols[c]) rows = rows & pat[c];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endfunction

    // Scoreboard: every key_valid pulse pops one expected code.
    logic [3:0] exp_q[$];
    int         pulse_cnt = 0;
    int         consec    = 0;
    logic       prev_kv   = 1'b0;

    always @(negedge clk) begin
        if (key_valid) begin
            logic [3:0] e;
            pulse_cnt++;
            if (prev_kv) consec++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("key_code", {28'd0, key_code}, {28'd0, e});
            end
        end
        prev_kv = key_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        pat[c] = ~(one << r);
    endtask

    task automatic release_all();
        for (int c = 0; c < 4; c++) pat[c] = 4'hF;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_pulse(input int budget, output int waited);
        waited = 0;
        while (!key_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("pulse_seen", {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_release(output int waited);
        waited = 0;
        while (key_held && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("key_held_fell", {31'd0, key_held}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    // Counts column-drive changes over n cycles.
    task automatic count_rotations(input int n, output int changes);
        logic [3:0] last;
        changes = 0;
        last = cols;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cols != last) changes++;
            last = cols;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] code;
        logic [3:0] old;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int         w;
        int         base;
        int         rotc;
        logic [3:0] exp_cols;
        logic [3:0] start_cols;

        vecs[0]  = '{2'd1, 2'd1, 4'h5, 4'h5};
        vecs[1]  = '{2'd0, 2'd3, 4'hA, 4'h5};
        vecs[2]  = '{2'd0, 2'd0, 4'h1, 4'hA};
        vecs[3]  = '{2'd0, 2'd1, 4'h2, 4'h1};
        vecs[4]  = '{2'd0, 2'd2, 4'h3, 4'h2};
        vecs[5]  = '{2'd1, 2'd0, 4'h4, 4'h3};
        vecs[6]  = '{2'd1, 2'd2, 4'h6, 4'h4};
        vecs[7]  = '{2'd1, 2'd3, 4'hB, 4'h6};
        vecs[8]  = '{2'd2, 2'd0, 4'h7, 4'hB};
        vecs[9]  = '{2'd2, 2'd1, 4'h8, 4'h7};
        vecs[10] = '{2'd2, 2'd2, 4'h9, 4'h8};
        vecs[11] = '{2'd2, 2'd3, 4'hC, 4'h9};
        vecs[12] = '{2'd3, 2'd0, 4'hE, 4'hC};
        vecs[13] = '{2'd3, 2'd1, 4'h0, 4'hE};
        vecs[14] = '{2'd3, 2'd2, 4'hF, 4'h0};
        vecs[15] = '{2'd3, 2'd3, 4'hD, 4'hF};

        release_all();

        // 1. reset values and idle column rotation, 4 cycles per column
        reset = 1'b1;
        wait_cycles(2);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code",  {28'd0, key_code},  32'd0);
        check("rst_digit_new", {28'd0, digit_new}, 32'd0);
        check("rst_digit_old", {28'd0, digit_old}, 32'd0);
        check("rst_key_held",  {31'd0, key_held},  32'd0);
        check("rst_state",     {29'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        exp_cols = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            check("idle_cols", {28'd0, cols}, {28'd0, exp_cols});
            @(negedge clk);
            if (i % 4 == 3) exp_cols = {exp_cols[2:0], exp_cols[3]};
        end

        // 2. '5' pressed right at reset release, held 40 cycles.
        // Column 1 is driven after 4 cycles, rs sees it 2 cycles later, the
        // dwell ends at cycle 8, then 8 debounce cycles: pulse visible at 16.
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        base = pulse_cnt;
        exp_q.push_back(4'h5);
        press(2'd1, 2'd1);
        wait_pulse(60, w);
        check("press_latency", w, 32'd16);
        check("p5_digit_new", {28'd0, digit_new}, 32'h5);
        check("p5_digit_old", {28'd0, digit_old}, 32'h0);
        check("p5_held_in_pressed", {31'd0, key_held}, 32'd0);
        wait_cycles(40 - w);
        check("p5_held", {31'd0, key_held}, 32'd1);
        release_all();
        // 2 sync cycles + 1 cycle for HOLD to see idle rows + 8 debounce
        wait_release(w);
        check("release_latency", w, 32'd11);
        check("p5_pulses", pulse_cnt - base, 32'd1);

        // 3. bouncing '5': rows[1] toggles every 3 cycles
        base = pulse_cnt;
        start_cols = cols;
        rotc = 0;
        for (int i = 0; i < 20; i++) begin
            int k;
            if (i % 2 == 0) press(2'd1, 2'd1);
            else release_all();
            count_rotations(3, k);
            rotc += k;
        end
        release_all();
        wait_cycles(20);
        check("bounce_no_pulse", pulse_cnt - base, 32'd0);
        check("bounce_rotating", {31'd0, rotc >= 8}, 32'd1);

        // 4. table: every key, pressed then released, checking the digit pair
        for (int v = 0; v < 16; v++) begin
            base = pulse_cnt;
            exp_q.push_back(vecs[v].code);
            press(vecs[v].row, vecs[v].col);
            wait_pulse(60, w);
            check("tbl_digit_new", {28'd0, digit_new}, {28'd0, vecs[v].code});
            check("tbl_digit_old", {28'd0, digit_old}, {28'd0, vecs[v].old});
            wait_cycles(6);
            check("tbl_key_held", {31'd0, key_held}, 32'd1);
            release_all();
            wait_release(w);
            check("tbl_release_latency", w, 32'd11);
            check("tbl_one_pulse", pulse_cnt - base, 32'd1);
        end

        // 5a. two rows low in column 0: treated as no key
        base = pulse_cnt;
        pat[0] = 4'b1010;
        count_rotations(40, rotc);
        release_all();
        wait_cycles(10);
        check("multi_no_pulse", pulse_cnt - base, 32'd0);
        check("multi_rotating", {31'd0, rotc >= 8}, 32'd1);

        // 5b. reset while in HOLD
        exp_q.push_back(4'h7);
        press(2'd2, 2'd0);
        wait_pulse(60, w);
        wait_cycles(2);
        check("hold_before_reset", {31'd0, key_held}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("hr_cols",      {28'd0, cols},      32'hE);
        check("hr_digit_new", {28'd0, digit_new}, 32'h0);
        check("hr_digit_old", {28'd0, digit_old}, 32'h0);
        check("hr_key_code",  {28'd0, key_code},  32'h0);
        check("hr_key_held",  {31'd0, key_held},  32'd0);
        release_all();
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(5);

        // 6. '5' held 100 cycles past accept
        base = pulse_cnt;
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(4'h5);
`else
        exp_q.push_back(4'h5);
`endif
        press(2'd1, 2'd1);
        wait_pulse(60, w);
        check("rp_digit_new", {28'd0, digit_new}, 32'h5);
        check("rp_digit_old", {28'd0, digit_old}, 32'h0);
        begin
            int last_k;
            last_k = 0;
            for (int k = 1; k <= 100; k++) begin
                @(negedge clk);
                if (key_valid) begin
                    check("repeat_spacing", k - last_k, REPEAT_CYCLES);
                    last_k = k;
                end
            end
        end
        release_all();
        wait_release(w);
`ifdef KEYPAD_REPEAT_EN
        check("repeat_pulses", pulse_cnt - base, 32'd4);
        check("repeat_digit_old", {28'd0, digit_old}, 32'h5);
`else
        check("repeat_pulses", pulse_cnt - base, 32'd1);
        check("repeat_digit_old", {28'd0, digit_old}, 32'h0);
`endif

        // final scoreboard state
        wait_cycles(5);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("no_back_to_back", consec, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
